// File: rtl/alu_mdu_pkg.sv
// Shared types, opcode map and op-class helpers for the execute ALU with M extension.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_mdu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    // Base ALU operation codes
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_ADDI   = 5'd10;
    localparam logic [4:0] OP_SLTI   = 5'd11;
    localparam logic [4:0] OP_SLTIU  = 5'd12;
    localparam logic [4:0] OP_XORI   = 5'd13;
    localparam logic [4:0] OP_ORI    = 5'd14;
    localparam logic [4:0] OP_ANDI   = 5'd15;
    localparam logic [4:0] OP_SLLI   = 5'd16;
    localparam logic [4:0] OP_SRLI   = 5'd17;
    localparam logic [4:0] OP_SRAI   = 5'd18;
    localparam logic [4:0] OP_LUI    = 5'd19;
    localparam logic [4:0] OP_AUIPC  = 5'd20;

    // M-extension codes occupy encodings the base set leaves free
    localparam logic [4:0] OP_MUL    = 5'd21;
    localparam logic [4:0] OP_MULH   = 5'd22;
    localparam logic [4:0] OP_MULHSU = 5'd23;
    localparam logic [4:0] OP_MULHU  = 5'd24;
    localparam logic [4:0] OP_DIV    = 5'd25;
    localparam logic [4:0] OP_DIVU   = 5'd26;
    localparam logic [4:0] OP_REM    = 5'd27;
    localparam logic [4:0] OP_REMU   = 5'd28;

    typedef struct packed {
        logic rs1_signed;
        logic rs2_signed;
    } sgn_t;

    function automatic logic is_mul(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // MUL's low half is sign-agnostic, so it is simply treated as signed x signed
    function automatic sgn_t op_signedness(input logic [4:0] op);
        sgn_t s;
        s = '0;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = '{rs1_signed: 1'b1, rs2_signed: 1'b1};
            OP_MULHSU:                       s = '{rs1_signed: 1'b1, rs2_signed: 1'b0};
            default:                         s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_mdu_divider.sv
// Iterative restoring divider on magnitudes, one quotient bit per cycle, then a sign-fix cycle.
// Latency: XLEN iteration cycles after start, then fix_vld for one cycle with signed results.
// Backpressure: none; the caller must not assert start while an operation is in flight.
// Ports: start/dividend/divisor/signed_op load an op; last_iter marks the final iteration;
//        fix_vld marks the cycle in which quotient/remainder carry the sign-corrected results.
module alu_mdu_divider
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_op,
    output logic            last_iter,
    output logic            fix_vld,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             fix_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    assign a_neg = signed_op & dividend[XLEN-1];
    assign b_neg = signed_op & divisor[XLEN-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    // Partial remainder is always below the divisor, so XLEN bits hold it between steps
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr_q};

    assign last_iter = run_q & (cnt_q == CNT_W'(XLEN - 1));
    assign fix_vld   = fix_q;
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            fix_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            fix_q <= 1'b0;
            if (start) begin
                quo_q     <= a_mag;
                rem_q     <= '0;
                dsr_q     <= b_mag;
                cnt_q     <= '0;
                run_q     <= 1'b1;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
            end else if (run_q) begin
                if (!diff[XLEN]) begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    run_q <= 1'b0;
                    fix_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with RV M extension: base ops, shift-add multiplier, restoring divider.
// Latency: base ops and divider special cases 1, MUL* XLEN+1, DIV*/REM* XLEN+2.
// Backpressure: result held in DONE until out_ready; in_ready low while busy or result unconsumed.
// Ports: in_valid/in_ready + operands/control/rd tag in; out_valid/out_ready + rd write info out;
//        flush kills in-flight work; busy flags an active multiply/divide iteration.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 5,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [4:0]        rd_addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rd_write_control,
    output logic [XLEN-1:0]   rd_write_val,
    output logic [4:0]        rd_addr_out,
    output logic              busy
);

    state_t              state;
    logic [4:0]          op_q;
    logic [2*XLEN-1:0]   mul_acc;
    logic [XLEN-1:0]     mcand_q;
    logic                mul_neg_q;
    logic [SHAMT_W-1:0]  mul_cnt;

    // Codes wider than the package map are only legal if the extra bits are zero
    logic [4:0]          op_code;
    logic                op_ext_ok;
    logic                in_is_mul;
    logic                in_is_div;
    logic                accept;
    sgn_t                in_sgn;
    logic                rs1_neg;
    logic                rs2_neg;
    logic [XLEN-1:0]     rs1_mag;
    logic [XLEN-1:0]     rs2_mag;

    logic                div_zero;
    logic                div_ovf;
    logic                div_special;
    logic                div_start;
    logic                div_clr;
    logic [XLEN-1:0]     div_special_val;
    logic                div_last;
    logic                div_fix_vld;
    logic [XLEN-1:0]     div_quo;
    logic [XLEN-1:0]     div_rem;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [2*XLEN-1:0]   mul_final;

    logic [XLEN-1:0]     base_res;
    logic                base_ok;
    logic [SHAMT_W-1:0]  shamt_r;
    logic [SHAMT_W-1:0]  shamt_i;

    assign op_code   = 5'(alu_control);
    assign op_ext_ok = ((32'(alu_control) >> 5) == 32'd0);
    assign in_is_mul = op_ext_ok & is_mul(op_code);
    assign in_is_div = op_ext_ok & is_div(op_code);
    assign in_sgn    = op_signedness(op_code);

    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_MUL) | (state == ST_DIV) | (state == ST_FIX);

    assign rs1_neg = in_sgn.rs1_signed & rs1_val[XLEN-1];
    assign rs2_neg = in_sgn.rs2_signed & rs2_val[XLEN-1];
    assign rs1_mag = rs1_neg ? -rs1_val : rs1_val;
    assign rs2_mag = rs2_neg ? -rs2_val : rs2_val;

    // Divider corner cases resolve at accept without iterating
    assign div_zero    = (rs2_val == '0);
    assign div_ovf     = in_sgn.rs1_signed & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
    assign div_special = div_zero | div_ovf;
    assign div_start   = accept & in_is_div & ~div_special;
    assign div_clr     = rst | flush;

    always_comb begin
        div_special_val = '0;
        if (div_zero) begin
            div_special_val = (op_code == OP_REM || op_code == OP_REMU) ? rs1_val : '1;
        end else begin
            div_special_val = (op_code == OP_REM || op_code == OP_REMU) ? '0 : rs1_val;
        end
    end

    // Shift-add step: high half accumulates the multiplicand, low half drains the multiplier
    assign mul_sum   = mul_acc[0] ? ({1'b0, mul_acc[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                                  : {1'b0, mul_acc[2*XLEN-1:XLEN]};
    assign mul_next  = {mul_sum, mul_acc[XLEN-1:1]};
    assign mul_final = mul_neg_q ? -mul_next : mul_next;

    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        shamt_r  = rs2_val[SHAMT_W-1:0];
        shamt_i  = imm[SHAMT_W-1:0];
        if (!op_ext_ok) begin
            base_ok = 1'b0;
        end else begin
            case (op_code)
                OP_ADD:   base_res = rs1_val + rs2_val;
                OP_SUB:   base_res = rs1_val - rs2_val;
                OP_SLL:   base_res = rs1_val << shamt_r;
                OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
                OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
                OP_XOR:   base_res = rs1_val ^ rs2_val;
                OP_SRL:   base_res = rs1_val >> shamt_r;
                OP_SRA:   base_res = $signed(rs1_val) >>> shamt_r;
                OP_OR:    base_res = rs1_val | rs2_val;
                OP_AND:   base_res = rs1_val & rs2_val;
                OP_ADDI:  base_res = rs1_val + imm;
                OP_SLTI:  base_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(imm)};
                OP_SLTIU: base_res = {{(XLEN-1){1'b0}}, rs1_val < imm};
                OP_XORI:  base_res = rs1_val ^ imm;
                OP_ORI:   base_res = rs1_val | imm;
                OP_ANDI:  base_res = rs1_val & imm;
                OP_SLLI:  base_res = rs1_val << shamt_i;
                OP_SRLI:  base_res = rs1_val >> shamt_i;
                OP_SRAI:  base_res = $signed(rs1_val) >>> shamt_i;
                OP_LUI:   base_res = imm;
                OP_AUIPC: base_res = pc + imm;
                default:  base_ok  = 1'b0;
            endcase
        end
    end

    alu_mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (div_clr),
        .start     (div_start),
        .dividend  (rs1_val),
        .divisor   (rs2_val),
        .signed_op (in_sgn.rs1_signed),
        .last_iter (div_last),
        .fix_vld   (div_fix_vld),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state            <= ST_IDLE;
            op_q             <= '0;
            rd_write_control <= 1'b0;
            rd_write_val     <= '0;
            rd_addr_out      <= '0;
            mul_acc          <= '0;
            mcand_q          <= '0;
            mul_neg_q        <= 1'b0;
            mul_cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q        <= op_code;
                        rd_addr_out <= rd_addr_in;
                        if (in_is_mul) begin
                            state     <= ST_MUL;
                            mul_acc   <= {{XLEN{1'b0}}, rs2_mag};
                            mcand_q   <= rs1_mag;
                            mul_neg_q <= rs1_neg ^ rs2_neg;
                            mul_cnt   <= '0;
                        end else if (in_is_div && div_special) begin
                            state            <= ST_DONE;
                            rd_write_control <= 1'b1;
                            rd_write_val     <= div_special_val;
                        end else if (in_is_div) begin
                            state <= ST_DIV;
                        end else begin
                            state            <= ST_DONE;
                            rd_write_control <= base_ok;
                            rd_write_val     <= base_res;
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    mul_cnt <= mul_cnt + SHAMT_W'(1);
                    if (mul_cnt == SHAMT_W'(XLEN - 1)) begin
                        // Final step also folds in the sign correction
                        mul_acc          <= mul_final;
                        state            <= ST_DONE;
                        rd_write_control <= 1'b1;
                        rd_write_val     <= (op_q == OP_MUL) ? mul_final[XLEN-1:0]
                                                             : mul_final[2*XLEN-1:XLEN];
                    end else begin
                        mul_acc <= mul_next;
                    end
                end
                ST_DIV: begin
                    if (div_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (div_fix_vld) begin
                        state            <= ST_DONE;
                        rd_write_control <= 1'b1;
                        rd_write_val     <= (op_q == OP_REM || op_q == OP_REMU) ? div_rem : div_quo;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  alu_control;
    logic [4:0]  rd_addr_in;
    logic        out_valid;
    logic        out_ready;
    logic        rd_write_control;
    logic [31:0] rd_write_val;
    logic [4:0]  rd_addr_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_mdu dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pc               (pc),
        .imm              (imm),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .alu_control      (alu_control),
        .rd_addr_in       (rd_addr_in),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .rd_write_control (rd_write_control),
        .rd_write_val     (rd_write_val),
        .rd_addr_out      (rd_addr_out),
        .busy             (busy)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        logic [31:0] p;
        logic [31:0] exp_v;
        logic        exp_wc;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p, input logic [4:0] tag);
        alu_control = op;
        rs1_val     = a;
        rs2_val     = b;
        imm         = im;
        pc          = p;
        rd_addr_in  = tag;
    endtask

    // One op with result held until checked; latency counted in cycles from the accept edge
    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                          input logic [31:0] exp_v, input logic exp_wc, input int exp_lat,
                          input logic [4:0] tag);
        int   lat;
        int   bsy;
        logic saw_rdy;
        @(negedge clk);
        chk({nm, " in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        set_op(op, a, b, im, p, tag);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        bsy = 0;
        saw_rdy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
            if (in_ready) saw_rdy = 1'b1;
        end while (!out_valid && lat < 100);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " value"}, rd_write_val, exp_v);
        chk({nm, " wr_ctl"}, {31'b0, rd_write_control}, {31'b0, exp_wc});
        chk({nm, " rd_addr"}, {27'b0, rd_addr_out}, {27'b0, tag});
        chk({nm, " busy_cycles"}, 32'(bsy), 32'(exp_lat - 1));
        chk({nm, " in_ready_low"}, {31'b0, saw_rdy}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Start DIV 100/7, kill it on its 10th cycle with flush or rst, then run SLL 1<<31
    task automatic abort_seq(input string nm, input logic use_rst);
        @(negedge clk);
        set_op(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 5'd20);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk);
        chk({nm, " busy_before"}, {31'b0, busy}, 32'd1);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        // An op offered in the kill cycle must be dropped
        set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd21);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, " busy_after"}, {31'b0, busy}, 32'd0);
        chk({nm, " out_valid_after"}, {31'b0, out_valid}, 32'd0);
        chk({nm, " in_ready_after"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk({nm, " no_ghost_result"}, {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        run_op({nm, " sll"}, OP_SLL, 32'd1, 32'd31, 32'd0, 32'd0, 32'h8000_0000, 1'b1, 1, 5'd22);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold_v;
        logic [4:0]  hold_rd;
        int          lat;

        // op, a, b, imm, pc, expected, expected write, latency
        vt.push_back('{OP_ADD,    32'd5,          32'd7,          32'd0,  32'd0,     32'd12,         1'b1, 1});
        vt.push_back('{OP_SUB,    32'd3,          32'd5,          32'd0,  32'd0,     32'hFFFF_FFFE,  1'b1, 1});
        vt.push_back('{OP_SLL,    32'd1,          32'h0000_0023,  32'd0,  32'd0,     32'd8,          1'b1, 1});
        vt.push_back('{OP_SRA,    32'h8000_0000,  32'd4,          32'd0,  32'd0,     32'hF800_0000,  1'b1, 1});
        vt.push_back('{OP_SRL,    32'h8000_0000,  32'd4,          32'd0,  32'd0,     32'h0800_0000,  1'b1, 1});
        vt.push_back('{OP_SRAI,   32'hF000_0000,  32'd0,          32'd8,  32'd0,     32'hFFF0_0000,  1'b1, 1});
        vt.push_back('{OP_SLT,    32'hFFFF_FFFF,  32'd1,          32'd0,  32'd0,     32'd1,          1'b1, 1});
        vt.push_back('{OP_SLTU,   32'hFFFF_FFFF,  32'd1,          32'd0,  32'd0,     32'd0,          1'b1, 1});
        vt.push_back('{OP_XORI,   32'h0F0F_0F0F,  32'd0,          32'hFF, 32'd0,     32'h0F0F_0FF0,  1'b1, 1});
        vt.push_back('{OP_AUIPC,  32'd0,          32'd0,          32'h1000, 32'h400, 32'h0000_1400,  1'b1, 1});
        vt.push_back('{OP_LUI,    32'd0,          32'd0,          32'hABCD_E000, 32'd0, 32'hABCD_E000, 1'b1, 1});
        vt.push_back('{5'd31,     32'd5,          32'd7,          32'd0,  32'd0,     32'd0,          1'b0, 1});
        vt.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'd2,          32'd0,  32'd0,     32'hFFFF_FFFF,  1'b1, 33});
        vt.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'd2,          32'd0,  32'd0,     32'h0000_0001,  1'b1, 33});
        vt.push_back('{OP_MUL,    32'hFFFF_FFFF,  32'd2,          32'd0,  32'd0,     32'hFFFF_FFFE,  1'b1, 33});
        vt.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'd0,  32'd0,     32'hFFFF_FFFF,  1'b1, 33});
        vt.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'd0,  32'd0,     32'h4000_0000,  1'b1, 33});
        vt.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'd0,  32'd0,     32'hFFFF_FFFD,  1'b1, 34});
        vt.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'd0,  32'd0,     32'hFFFF_FFFF,  1'b1, 34});
        vt.push_back('{OP_DIVU,   32'd100,        32'd7,          32'd0,  32'd0,     32'd14,         1'b1, 34});
        vt.push_back('{OP_REMU,   32'd100,        32'd7,          32'd0,  32'd0,     32'd2,          1'b1, 34});
        vt.push_back('{OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'd0,  32'd0,     32'hFFFF_FFFD,  1'b1, 34});
        vt.push_back('{OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd0,  32'd0,     32'd1,          1'b1, 34});
        vt.push_back('{OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,  32'd0,     32'd0,          1'b1, 34});
        vt.push_back('{OP_DIVU,   32'h1234,       32'd0,          32'd0,  32'd0,     32'hFFFF_FFFF,  1'b1, 1});
        vt.push_back('{OP_REM,    32'h1234,       32'd0,          32'd0,  32'd0,     32'h0000_1234,  1'b1, 1});
        vt.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,  32'd0,     32'h8000_0000,  1'b1, 1});
        vt.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,  32'd0,     32'd0,          1'b1, 1});

        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_op(OP_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst wr_ctl", {31'b0, rd_write_control}, 32'd0);
        chk("rst value", rd_write_val, 32'd0);
        chk("rst rd_addr", {27'b0, rd_addr_out}, 32'd0);

        foreach (vt[i]) begin
            run_op($sformatf("v%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].im, vt[i].p,
                   vt[i].exp_v, vt[i].exp_wc, vt[i].lat, 5'(i + 1));
        end

        // Back-to-back ADD then SUB with out_ready held high
        @(negedge clk);
        set_op(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd11);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b add valid", {31'b0, out_valid}, 32'd1);
        chk("b2b add value", rd_write_val, 32'd12);
        chk("b2b add rd", {27'b0, rd_addr_out}, 32'd11);
        chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
        set_op(OP_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 5'd12);
        @(negedge clk);
        chk("b2b sub valid", {31'b0, out_valid}, 32'd1);
        chk("b2b sub value", rd_write_val, 32'hFFFF_FFFE);
        chk("b2b sub rd", {27'b0, rd_addr_out}, 32'd12);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b drained", {31'b0, out_valid}, 32'd0);

        // Backpressure on a MUL result, then a back-to-back ADD on release
        out_ready = 1'b0;
        set_op(OP_MUL, 32'd3, 32'd5, 32'd0, 32'd0, 5'd13);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        chk("bp mul latency", 32'(lat), 32'd33);
        chk("bp mul value", rd_write_val, 32'd15);
        hold_v = rd_write_val;
        hold_rd = rd_addr_out;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp hold%0d value", k), rd_write_val, 32'd15);
            chk($sformatf("bp hold%0d rd", k), {27'b0, rd_addr_out}, {27'b0, hold_rd});
            chk($sformatf("bp hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
        end
        chk("bp held value", hold_v, 32'd15);
        out_ready = 1'b1;
        set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd14);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp add valid", {31'b0, out_valid}, 32'd1);
        chk("bp add value", rd_write_val, 32'd2);
        chk("bp add rd", {27'b0, rd_addr_out}, 32'd14);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Pending DONE result discarded by flush
        @(negedge clk);
        set_op(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 5'd15);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("flush done valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush done dropped", {31'b0, out_valid}, 32'd0);
        chk("flush done in_ready", {31'b0, in_ready}, 32'd1);

        abort_seq("flush", 1'b0);
        abort_seq("rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
